// File: rtl/adc_wavelet_pkg.sv
// rtl/adc_wavelet_pkg.sv - shared constants, sample type and parameter check for the ADC sample window
//
// Purpose: shared definitions for adc_sample_window and adc_level_window.
//   ADC_WIDTH_DEF      default bits per ADC sample
//   TAPS_* / LEVELS_*  legal ranges for window depth and decimation levels
//   adc_sample_t       one sample at the default width
//   params_legal()     elaboration-time range check used by the top
package adc_wavelet_pkg;

  localparam int ADC_WIDTH_DEF = 14;
  localparam int TAPS_MIN      = 2;
  localparam int TAPS_MAX      = 16;
  localparam int LEVELS_MIN    = 1;
  localparam int LEVELS_MAX    = 8;

  typedef logic [ADC_WIDTH_DEF-1:0] adc_sample_t;

  function automatic bit params_legal(input int taps, input int levels);
    return (taps >= TAPS_MIN) && (taps <= TAPS_MAX) &&
           (levels >= LEVELS_MIN) && (levels <= LEVELS_MAX);
  endfunction

endpackage

// File: rtl/adc_level_window.sv
// rtl/adc_level_window.sv - one decimation level: tap shift register, fill counter, valid/primed flags
//
// Purpose: holds the last TAPS samples delivered to this level.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush           clears taps and fill count
//   upd             shift sample in on this edge
//   sample          incoming sample
//   taps            tap t at [t*ADC_WIDTH +: ADC_WIDTH], tap 0 newest
//   win_valid       one-cycle pulse after an update that leaves the window full
//   win_primed      window holds TAPS samples since last reset/flush
module adc_level_window
  import adc_wavelet_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int TAPS      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      upd,
  input  logic [ADC_WIDTH-1:0]      sample,
  output logic [TAPS*ADC_WIDTH-1:0] taps,
  output logic                      win_valid,
  output logic                      win_primed
);

  localparam int FW = $clog2(TAPS + 1);
  localparam logic [FW-1:0] FULL = FW'(TAPS);

  logic [FW-1:0] fill;
  logic [FW-1:0] fill_next;

  // Saturating so the window stays "full" forever once primed.
  assign fill_next  = (fill == FULL) ? FULL : fill + FW'(1);
  assign win_primed = (fill == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      taps      <= '0;
      fill      <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      if (upd) begin
        taps      <= {taps[(TAPS-1)*ADC_WIDTH-1:0], sample};
        fill      <= fill_next;
        win_valid <= (fill_next == FULL);
      end
    end
  end

endmodule

// File: rtl/adc_sample_window.sv
// rtl/adc_sample_window.sv - multi-level decimated sliding windows over an ADC sample stream
//
// Purpose: aligns incoming samples through VALID_DELAY stages, then feeds
//   LEVELS windows; level k takes every 2^k-th sample since reset/flush.
// Optional feature: ADC_OFFSET_BINARY_EN inverts the input MSB at the first
//   pipeline stage (offset-binary to two's complement).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   adc_data_in         raw sample
//   adc_data_in_valid   sample accepted on this edge
//   flush               clear windows, phases, fills and in-flight samples
//   win_data            level l tap t at [(l*TAPS+t)*ADC_WIDTH +: ADC_WIDTH]
//   win_valid           per-level pulse on update of a full window
//   win_primed          per-level window-full flag
module adc_sample_window
  import adc_wavelet_pkg::*;
#(
  parameter int ADC_WIDTH   = ADC_WIDTH_DEF,
  parameter int TAPS        = 4,
  parameter int LEVELS      = 3,
  parameter int VALID_DELAY = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADC_WIDTH-1:0]             adc_data_in,
  input  logic                             adc_data_in_valid,
  input  logic                             flush,
  output logic [LEVELS*TAPS*ADC_WIDTH-1:0] win_data,
  output logic [LEVELS-1:0]                win_valid,
  output logic [LEVELS-1:0]                win_primed
);

  localparam bit PARAMS_OK = params_legal(TAPS, LEVELS);

  if (!PARAMS_OK) begin : g_illegal_params
    $error("adc_sample_window: TAPS or LEVELS out of range");
  end

  logic [ADC_WIDTH-1:0]   first_data;
  logic [ADC_WIDTH-1:0]   pipe_data [VALID_DELAY];
  logic [VALID_DELAY-1:0] pipe_valid;
  logic                   dv;
  logic [LEVELS-1:0]      upd;

`ifdef ADC_OFFSET_BINARY_EN
  assign first_data = {~adc_data_in[ADC_WIDTH-1], adc_data_in[ADC_WIDTH-2:0]};
`else
  assign first_data = adc_data_in;
`endif

  // Data needs no reset: only the valid bits decide whether it is used.
  always_ff @(posedge clk) begin
    pipe_data[0] <= first_data;
    for (int i = 1; i < VALID_DELAY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  // Flush empties the pipeline too, so samples accepted around it never land.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= adc_data_in_valid;
      for (int i = 1; i < VALID_DELAY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Flush wins over a coincident arriving sample.
  assign dv     = pipe_valid[VALID_DELAY-1] && !flush;
  assign upd[0] = dv;

  // Level k shifts on even-numbered updates of level k-1; the phase bit
  // flips on every level k-1 update, so phase==0 marks samples 0,2,4...
  for (genvar k = 1; k < LEVELS; k++) begin : g_phase
    logic phase;

    always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
        phase <= 1'b0;
      end else if (upd[k-1]) begin
        phase <= ~phase;
      end
    end

    assign upd[k] = upd[k-1] && !phase;
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    adc_level_window #(
      .ADC_WIDTH (ADC_WIDTH),
      .TAPS      (TAPS)
    ) u_level (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .upd        (upd[l]),
      .sample     (pipe_data[VALID_DELAY-1]),
      .taps       (win_data[l*TAPS*ADC_WIDTH +: TAPS*ADC_WIDTH]),
      .win_valid  (win_valid[l]),
      .win_primed (win_primed[l])
    );
  end

endmodule

// File: doc/adc_sample_window.md
ADC_SAMPLE_WINDOW -- requirements
Module: adc_sample_window

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 14, meaning bits per ADC sample.
REQ-002 SHALL have parameter TAPS, default 4, legal range 2..16, meaning samples held per level window.
REQ-003 SHALL have parameter LEVELS, default 3, legal range 1..8, meaning decimation levels (level k holds every 2^k-th sample).
REQ-004 SHALL have parameter VALID_DELAY, default 3, legal range 1..8, meaning input-to-window alignment stages.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-007 SHALL have port adc_data_in, input, ADC_WIDTH, meaning the raw ADC sample.
REQ-008 SHALL have port adc_data_in_valid, input, 1, meaning the sample is accepted on this edge.
REQ-009 SHALL have port flush, input, 1, meaning clear all windows and phases without reset.
REQ-010 SHALL have port win_data, output, LEVELS*TAPS*ADC_WIDTH, meaning level l, tap t at bits [(l*TAPS+t)*ADC_WIDTH +: ADC_WIDTH]; tap 0 is newest.
REQ-011 SHALL have port win_valid, output, LEVELS, meaning one-cycle pulse per level on each update of a full window.
REQ-012 SHALL have port win_primed, output, LEVELS, meaning the level window holds TAPS samples since the last reset or flush.

Function
REQ-013 SHALL carry data and valid together through VALID_DELAY registered stages; a sample accepted at edge T SHALL reach level 0 at edge T+VALID_DELAY.
REQ-014 SHALL shift level 0 on every delayed-valid edge: tap t <= tap t-1, tap 0 <= new sample.
REQ-015 SHALL keep a phase bit per level k>=1, toggling on each level k-1 update; level k SHALL shift when level k-1 shifts with phase k == 0 (samples 0,2,4.. of level k-1).
REQ-016 SHALL shift the same incoming sample into all levels updating on the same edge.
REQ-017 SHALL keep a fill counter per level, saturating at TAPS, incremented on each update of that level.
REQ-018 SHALL assert win_valid[l] in the cycle after the edge where level l updates and its fill count (post-update) equals TAPS; otherwise low.
REQ-019 SHALL hold all windows, phases and fills unchanged on edges without delayed valid.
REQ-020 SHALL give flush priority over a coincident delayed valid: windows zeroed, phases and fills cleared, that sample dropped, win_valid low next cycle.
REQ-021 SHALL clear only the alignment pipeline valid bits on flush, so samples accepted during flush are also dropped.

Reset
REQ-022 SHALL, on rst_n low at a rising edge, set win_data, win_valid, win_primed, all phases, fills and pipeline valid bits to 0.
REQ-023 SHALL discard any sample in flight when reset is asserted mid-stream; first post-reset sample is sample index 0 for all levels.

Configuration
REQ-024 SHALL support macro ADC_OFFSET_BINARY_EN: when defined, the input MSB SHALL be inverted at the first pipeline stage (offset-binary to two's complement); when undefined, samples pass unmodified.

Structure
REQ-025 SHALL place ADC_WIDTH default, TAPS/LEVELS limits and a sample typedef in shared package adc_wavelet_pkg.
REQ-026 SHALL instantiate sub-module adc_level_window once per level (shift register, fill counter, win_valid/primed generation); decimation phase logic SHALL live in the top.

Verification (TAPS=4, LEVELS=3, VALID_DELAY=3)
REQ-027 SHALL check: samples 1..16 back-to-back -> level 0 first win_valid on sample 4 with taps {4,3,2,1}, 4 edges after its input edge.
REQ-028 SHALL check: same stream -> level 1 first win_valid on sample 7 with {7,5,3,1}; level 2 first on sample 13 with {13,9,5,1}.
REQ-029 SHALL check: valid every third cycle, samples 1..8 -> level 0 contents identical to back-to-back case, no win_valid on idle cycles.
REQ-030 SHALL check: flush coincident with delayed sample 6 -> windows zero, win_primed 0, sample 6 absent, next sample treated as index 0.
REQ-031 SHALL check: rst_n low for one edge after sample 5 -> all outputs 0; samples 6..9 give level 0 first win_valid with {9,8,7,6}.
REQ-032 SHALL check: ADC_OFFSET_BINARY_EN defined, input 14'h2000 and 14'h0000 -> taps 14'h0000 and 14'h2000.
